// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  // A factor is usable when it yields at least one low and one high cycle.
  function automatic logic div_legal(input int n, input int max_div);
    return (n >= 2) && (n <= max_div);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and divided-clock/tick generator; holds the factor in force.
module clk_div_core #(
  parameter int MAX_DIV = 16,
  parameter int RST_DIV = 4,
  localparam int CW = $clog2(MAX_DIV + 1)
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          run_next,
  input  logic          load,
  input  logic [CW-1:0] load_div,
  output logic          at_last,
  output logic          clk_out,
  output logic          tick,
  output logic [CW-1:0] active_div
);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] div_reg, div_next;
  logic          run_reg;
  logic          clk_out_reg;
  logic          tick_reg;

  assign at_last = run_reg && (cnt_reg == div_reg - 1'b1);

  // Outputs are registered from the next count so they line up with cnt_reg.
  always_comb begin
    div_next = load ? load_div : div_reg;
    cnt_next = '0;
    if (run_next && run_reg && !at_last)
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_reg     <= '0;
      div_reg     <= CW'(RST_DIV);
      run_reg     <= 1'b0;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      div_reg     <= div_next;
      run_reg     <= run_next;
      clk_out_reg <= run_next && (cnt_next >= (div_next >> 1));
      tick_reg    <= run_next && (cnt_next == '0);
    end
  end

  assign clk_out    = clk_out_reg;
  assign tick       = tick_reg;
  assign active_div = div_reg;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: run/stop FSM, factor handshake and pending-factor register.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int MAX_DIV = 16,
  parameter int RST_DIV = 4,
  localparam int CW = $clog2(MAX_DIV + 1)
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          en,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_div,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic          clk_out,
  output logic          tick,
  output logic [CW-1:0] active_div
);

  state_t        state_reg;
  logic [CW-1:0] pend_reg;
  logic          cfg_ready_reg;
  logic          cfg_err_reg;

  logic          accept;
  logic          take;
  logic          at_last;
  logic          run_next;
  logic          load;
  logic [CW-1:0] load_div;

  assign accept = cfg_valid && cfg_ready_reg;
  assign take   = accept && div_legal(int'(cfg_div), MAX_DIV);

  // Core controls: a factor only ever reaches the core at a period boundary
  // or while stopped, so no phase can be truncated by a reconfiguration.
  always_comb begin
    run_next = 1'b0;
    load     = 1'b0;
    load_div = cfg_div;
    case (state_reg)
      ST_OFF: begin
        run_next = en;
        load     = take;
      end
      ST_RUN: begin
        run_next = !at_last || en;
        load     = take && at_last;
      end
      ST_PEND: begin
        run_next = !at_last || en;
        load     = at_last;
        load_div = pend_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg     <= ST_OFF;
      pend_reg      <= '0;
      cfg_ready_reg <= 1'b1;
      cfg_err_reg   <= 1'b0;
    end else begin
      cfg_err_reg <= accept && !take;
      case (state_reg)
        ST_OFF: begin
          if (en)
            state_reg <= ST_RUN;
        end
        ST_RUN: begin
          if (at_last) begin
            state_reg <= en ? ST_RUN : ST_OFF;
          end else if (take) begin
            state_reg     <= ST_PEND;
            pend_reg      <= cfg_div;
            cfg_ready_reg <= 1'b0;
          end
        end
        ST_PEND: begin
          if (at_last) begin
            state_reg     <= en ? ST_RUN : ST_OFF;
            pend_reg      <= '0;
            cfg_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= ST_OFF;
          cfg_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_reg;
  assign cfg_err   = cfg_err_reg;

  clk_div_core #(
    .MAX_DIV(MAX_DIV),
    .RST_DIV(RST_DIV)
  ) u_core (
    .clk_in    (clk_in),
    .rst       (rst),
    .run_next  (run_next),
    .load      (load),
    .load_div  (load_div),
    .at_last   (at_last),
    .clk_out   (clk_out),
    .tick      (tick),
    .active_div(active_div)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed, table-driven bench for clk_div_ctrl (MAX_DIV=16, RST_DIV=4).
module tb_clk_div_ctrl;

  logic       clk_in;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [4:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_out;
  logic       tick;
  logic [4:0] active_div;

  int n_total;
  int n_pass;

  typedef struct {
    logic       rst;
    logic       en;
    logic       vld;
    logic [4:0] div;
    logic       rdy;
    logic       err;
    logic       co;
    logic       tk;
    logic [4:0] ad;
  } vec_t;

  vec_t vecs[$];

  clk_div_ctrl #(
    .MAX_DIV(16),
    .RST_DIV(4)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .active_div(active_div)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic v(input logic r, input logic e, input logic vl, input logic [4:0] d,
                   input logic rdy, input logic err, input logic co, input logic tk,
                   input logic [4:0] ad);
    vec_t x;
    x.rst = r; x.en = e; x.vld = vl; x.div = d;
    x.rdy = rdy; x.err = err; x.co = co; x.tk = tk; x.ad = ad;
    vecs.push_back(x);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic vl, input logic [4:0] d);
    @(negedge clk_in);
    rst = r; en = e; cfg_valid = vl; cfg_div = d;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    else begin
      n_pass++;
      $display("ok   %s value=%h", name, act);
    end
  endtask

  initial begin
    int cyc;
    int hi;
    bit got;
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;

    // rst en vld div | rdy err clk_out tick active_div
    v(1,0,0, 0, 1,0,0,0,4);
    v(0,0,0, 0, 1,0,0,0,4);
    // N=4 run: 0,0,1,1 with tick at cnt 0
    v(0,1,0, 0, 1,0,0,1,4);
    v(0,1,0, 0, 1,0,0,0,4);
    v(0,1,0, 0, 1,0,1,0,4);
    v(0,1,0, 0, 1,0,1,0,4);
    v(0,1,0, 0, 1,0,0,1,4);
    v(0,1,0, 0, 1,0,0,0,4);
    v(0,1,0, 0, 1,0,1,0,4);
    v(0,1,0, 0, 1,0,1,0,4);
    v(0,1,0, 0, 1,0,0,1,4);
    v(0,1,0, 0, 1,0,0,0,4);
    // accept 7 at cnt 1 -> PEND; a request while not ready is ignored
    v(0,1,1, 7, 0,0,1,0,4);
    v(0,1,1, 9, 0,0,1,0,4);
    v(0,1,0, 0, 1,0,0,1,7);
    v(0,1,0, 0, 1,0,0,0,7);
    v(0,1,0, 0, 1,0,0,0,7);
    v(0,1,0, 0, 1,0,1,0,7);
    v(0,1,0, 0, 1,0,1,0,7);
    v(0,1,0, 0, 1,0,1,0,7);
    v(0,1,0, 0, 1,0,1,0,7);
    v(0,1,0, 0, 1,0,0,1,7);
    // illegal factors 1 and 17: error pulse, period untouched
    v(0,1,1, 1, 1,1,0,0,7);
    v(0,1,0, 0, 1,0,0,0,7);
    v(0,1,1,17, 1,1,1,0,7);
    v(0,1,0, 0, 1,0,1,0,7);
    v(0,1,0, 0, 1,0,1,0,7);
    v(0,1,0, 0, 1,0,1,0,7);
    v(0,1,0, 0, 1,0,0,1,7);
    v(0,1,0, 0, 1,0,0,0,7);
    v(0,1,0, 0, 1,0,0,0,7);
    v(0,1,0, 0, 1,0,1,0,7);
    v(0,1,0, 0, 1,0,1,0,7);
    v(0,1,0, 0, 1,0,1,0,7);
    v(0,1,0, 0, 1,0,1,0,7);
    // accept 6 on the last count: applied immediately, stays in RUN
    v(0,1,1, 6, 1,0,0,1,6);
    v(0,1,0, 0, 1,0,0,0,6);
    // en dropped at cnt 1: finish period, then OFF
    v(0,0,0, 0, 1,0,0,0,6);
    v(0,0,0, 0, 1,0,1,0,6);
    v(0,0,0, 0, 1,0,1,0,6);
    v(0,0,0, 0, 1,0,1,0,6);
    v(0,0,0, 0, 1,0,0,0,6);
    v(0,0,0, 0, 1,0,0,0,6);
    // factor 5 in OFF, then run: 2 low / 3 high
    v(0,0,1, 5, 1,0,0,0,5);
    v(0,1,0, 0, 1,0,0,1,5);
    v(0,1,0, 0, 1,0,0,0,5);
    v(0,1,0, 0, 1,0,1,0,5);
    v(0,1,0, 0, 1,0,1,0,5);
    v(0,1,0, 0, 1,0,1,0,5);
    v(0,1,0, 0, 1,0,0,1,5);
    // PEND with 9, then rst at cnt 3 (overrides en/cfg_valid)
    v(0,1,1, 9, 0,0,0,0,5);
    v(0,1,0, 0, 0,0,1,0,5);
    v(0,1,0, 0, 0,0,1,0,5);
    v(1,1,1, 3, 1,0,0,0,4);
    v(0,1,0, 0, 1,0,0,1,4);
    v(0,1,0, 0, 1,0,0,0,4);
    v(0,1,0, 0, 1,0,1,0,4);
    v(0,1,0, 0, 1,0,1,0,4);
    v(0,1,0, 0, 1,0,0,1,4);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].div);
      chk($sformatf("row%0d", i),
          {cfg_ready, cfg_err, clk_out, tick, active_div},
          {vecs[i].rdy, vecs[i].err, vecs[i].co, vecs[i].tk, vecs[i].ad});
    end

    // en low for one cycle mid-period, back high before the boundary
    step(0,0,0,0);
    step(0,1,0,0);
    step(0,1,0,0);
    step(0,1,0,0);
    chk("stop_cancel", {7'd0, tick, clk_out}, {7'd0, 1'b1, 1'b0});

    // pending factor applied at the boundary where the divider stops
    step(0,1,1,3);
    chk("pend_ready", {8'd0, cfg_ready}, 9'd0);
    step(0,0,0,0);
    step(0,0,0,0);
    step(0,0,0,0);
    chk("stop_pend", {1'b0, cfg_ready, clk_out, tick, active_div}, {1'b0, 1'b1, 1'b0, 1'b0, 5'd3});
    for (int i = 0; i < 3; i++) begin
      step(0,0,0,0);
      chk($sformatf("off_idle%0d", i), {7'd0, clk_out, tick}, 9'd0);
    end

    // MAX_DIV accepted, 0 rejected, then en with a new factor in the same cycle
    step(0,0,1,16);
    chk("max_div", {3'd0, cfg_err, active_div}, {3'd0, 1'b0, 5'd16});
    step(0,0,1,0);
    chk("zero_div", {3'd0, cfg_err, active_div}, {3'd0, 1'b1, 5'd16});
    step(0,1,1,6);
    chk("en_cfg_start", {2'd0, tick, clk_out, active_div}, {2'd0, 1'b1, 1'b0, 5'd6});

    cyc = 0;
    hi  = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(0,1,0,0);
      cyc++;
      if (tick) got = 1'b1;
      else hi += int'(clk_out);
    end
    chk("period6", 9'(cyc), 9'd6);
    chk("high6", 9'(hi), 9'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter MAX_DIV, default 16, the largest division factor accepted (legal range 3..255).
REQ-002 SHALL have parameter RST_DIV, default 4, the factor loaded at reset (2..MAX_DIV).
REQ-003 SHALL derive localparam CW = $clog2(MAX_DIV+1), the width of factor and counter fields.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock. Every flop is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: divider run request.
REQ-007 SHALL have port cfg_valid, input, 1 bit: new-factor request.
REQ-008 SHALL have port cfg_div, input, CW bits: requested factor N.
REQ-009 SHALL have port cfg_ready, output, 1 bit: controller can accept a factor.
REQ-010 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when an illegal factor is accepted.
REQ-011 SHALL have port clk_out, output, 1 bit: registered divided clock.
REQ-012 SHALL have port tick, output, 1 bit: one-cycle pulse on the first clk_in cycle of each clk_out period.
REQ-013 SHALL have port active_div, output, CW bits: factor currently in force.

Function
REQ-014 SHALL implement states OFF, RUN and PEND.
REQ-015 SHALL hold cfg_ready at 1 in OFF and RUN, and at 0 in PEND.
REQ-016 SHALL accept a factor on a cycle with cfg_valid=1 and cfg_ready=1.
REQ-017 SHALL treat an accepted factor N as legal if 2 <= N <= MAX_DIV.
REQ-018 SHALL, for an accepted illegal factor, pulse cfg_err=1 on the next cycle, leave state and active_div unchanged, and not enter PEND.
REQ-019 SHALL use a period counter cnt that runs 0..N-1 in RUN/PEND and wraps N-1 -> 0.
REQ-020 SHALL drive clk_out=0 while cnt < N/2 (integer division) and clk_out=1 otherwise.
REQ-021 SHALL give a period of exactly N clk_in cycles: low for floor(N/2) cycles, high for ceil(N/2) cycles (odd N: the high phase is one cycle longer).
REQ-022 SHALL assert tick in each cycle where cnt=0 in RUN/PEND; tick is 0 in OFF.
REQ-023 OFF: SHALL hold cnt=0, clk_out=0 and tick=0.
REQ-024 OFF: a legal accepted factor SHALL update active_div on the next cycle.
REQ-025 OFF -> RUN SHALL occur when en=1; the first cnt=0/tick cycle is the cycle after en is sampled high.
REQ-026 RUN: a legal accepted factor SHALL be latched and the state SHALL move to PEND, unless cnt=N-1 in the accept cycle.
REQ-027 RUN: if cnt=N-1 in the accept cycle, SHALL apply the factor immediately, so the next period uses the new N, and stay in RUN.
REQ-028 PEND: at the cycle with cnt=N-1, SHALL load the pending factor into active_div, wrap cnt to 0 and return to RUN.
REQ-029 SHALL change a factor only at a period boundary: clk_out never has a phase shorter than min(old, new) floor(N/2).
REQ-030 SHALL, when en=0 is sampled in RUN or PEND, finish the current period and then go to OFF with clk_out=0; any pending factor is applied at that boundary.
REQ-031 SHALL, if en returns to 1 before that boundary, cancel the stop.
REQ-032 SHALL, when en and a legal cfg arrive together in OFF, use the new factor for the first period.

Reset
REQ-033 SHALL, with rst=1 at a rising edge, set state=OFF, cnt=0, clk_out=0, tick=0, cfg_err=0, cfg_ready=1 (on the following cycle), active_div=RST_DIV and clear the pending factor.
REQ-034 SHALL let rst override en and cfg_valid in the same cycle.
REQ-035 SHALL, when rst is asserted mid-period, drop clk_out to 0 on the next edge; the truncated period is permitted.

Structure
REQ-036 SHALL place the state enum (OFF/RUN/PEND) and the factor-legality check function in shared package clk_div_pkg.
REQ-037 SHALL implement cnt, the clk_out/tick generation and the load of a new N as sub-module clk_div_core.
REQ-038 SHALL keep the FSM, handshake and pending register in clk_div_ctrl.

Verification
REQ-039 SHALL cover: reset, then en=1 with RST_DIV=4 -> clk_out 0,0,1,1 repeating, tick every 4 cycles, active_div=4.
REQ-040 SHALL cover: cfg_div=5 accepted in OFF, then en=1 -> clk_out low 2 / high 3 cycles, period 5.
REQ-041 SHALL cover: in RUN N=4, cfg_div=7 accepted at cnt=1 -> cfg_ready=0 until the boundary, the current period completes at 4 cycles, the next period is 7 cycles (3 low / 4 high), and active_div changes only at the boundary.
REQ-042 SHALL cover: cfg_div=1 and then cfg_div=MAX_DIV+1 -> one cfg_err pulse each, with no change in the period or state.
REQ-043 SHALL cover: en dropped at cnt=1 of N=6 -> the period finishes (cnt reaches 5), then clk_out=0, tick=0 and state=OFF.
REQ-044 SHALL cover: rst asserted at cnt=3 of N=5 while in PEND -> next cycle clk_out=0, active_div=RST_DIV and the pending factor is discarded.
